// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable driven VGA raster counters with registered sync/blank/strobe decode
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        pix_tick,
   output logic        horiz_sync,
   output logic        vert_sync,
   output logic        video_on,
   output logic [11:0] pixel_column,
   output logic [11:0] pixel_row,
   output logic        frame_start,
   output logic        line_start
);
   localparam logic [11:0] H_VIS = 12'(H_ACTIVE);
   localparam logic [11:0] H_SB  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SE  = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_MAX = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_VIS = 12'(V_ACTIVE);
   localparam logic [11:0] V_SB  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SE  = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_MAX = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   logic [11:0] hc, vc;
   logic        h_end, v_end;

   assign h_end = hc == H_MAX;
   assign v_end = vc == V_MAX;

   // raster position: hc wraps each line, vc advances on the hc wrap
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else if (pix_tick) begin
         hc <= h_end ? 12'd0 : hc + 12'd1;
         vc <= h_end ? (v_end ? 12'd0 : vc + 12'd1) : vc;
      end
   end

   // outputs register the decode of the pre-increment position so all fields describe the same pixel
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         pixel_column <= '0;
         pixel_row    <= '0;
         video_on     <= 1'b0;
         frame_start  <= 1'b0;
         line_start   <= 1'b0;
         horiz_sync   <= ~SYNC_POL;
         vert_sync    <= ~SYNC_POL;
      end else if (pix_tick) begin
         pixel_column <= hc;
         pixel_row    <= vc;
         video_on     <= (hc < H_VIS) && (vc < V_VIS);
         frame_start  <= (hc == 12'd0) && (vc == 12'd0);
         line_start   <= hc == 12'd0;
         horiz_sync   <= (hc >= H_SB && hc < H_SE) ? SYNC_POL : ~SYNC_POL;
         vert_sync    <= (vc >= V_SB && vc < V_SE) ? SYNC_POL : ~SYNC_POL;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for full-size and reduced-size raster timing, both sync polarities
module tb_vga_timing_gen;
   logic clock = 1'b0;
   logic rst_n = 1'b0;
   logic pix_tick = 1'b0;

   always #5 clock = ~clock;

   // instance 0: default 640x480; instance 1: small raster active-low; instance 2: small raster active-high
   logic        hs_d, vs_d, von_d, fs_d, ls_d;
   logic [11:0] col_d, row_d;
   logic        hs_s, vs_s, von_s, fs_s, ls_s;
   logic [11:0] col_s, row_s;
   logic        hs_p, vs_p, von_p, fs_p, ls_p;
   logic [11:0] col_p, row_p;

   vga_timing_gen dut_d (
      .clock(clock), .rst_n(rst_n), .pix_tick(pix_tick),
      .horiz_sync(hs_d), .vert_sync(vs_d), .video_on(von_d),
      .pixel_column(col_d), .pixel_row(row_d), .frame_start(fs_d), .line_start(ls_d));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0)) dut_s (
      .clock(clock), .rst_n(rst_n), .pix_tick(pix_tick),
      .horiz_sync(hs_s), .vert_sync(vs_s), .video_on(von_s),
      .pixel_column(col_s), .pixel_row(row_s), .frame_start(fs_s), .line_start(ls_s));

   vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)) dut_p (
      .clock(clock), .rst_n(rst_n), .pix_tick(pix_tick),
      .horiz_sync(hs_p), .vert_sync(vs_p), .video_on(von_p),
      .pixel_column(col_p), .pixel_row(row_p), .frame_start(fs_p), .line_start(ls_p));

   logic [28:0] obs [3];
   assign obs[0] = {hs_d, vs_d, von_d, fs_d, ls_d, col_d, row_d};
   assign obs[1] = {hs_s, vs_s, von_s, fs_s, ls_s, col_s, row_s};
   assign obs[2] = {hs_p, vs_p, von_p, fs_p, ls_p, col_p, row_p};

   int ha [3] = '{640, 8, 8};
   int hf [3] = '{16, 2, 2};
   int hw [3] = '{96, 3, 3};
   int hb [3] = '{48, 3, 3};
   int va [3] = '{480, 6, 6};
   int vf [3] = '{10, 2, 2};
   int vw [3] = '{2, 2, 2};
   int vb [3] = '{33, 2, 2};
   bit pol [3] = '{1'b0, 1'b0, 1'b1};

   int mh [3];
   int mv [3];
   logic [28:0] mo [3];
   logic [28:0] q [$];

   int vectors = 0;
   int miscompares = 0;

   function automatic logic [28:0] dec(int i, int h, int v);
      logic hs, vs, von, fs, ls;
      hs  = (h >= ha[i] + hf[i] && h < ha[i] + hf[i] + hw[i]) ? pol[i] : ~pol[i];
      vs  = (v >= va[i] + vf[i] && v < va[i] + vf[i] + vw[i]) ? pol[i] : ~pol[i];
      von = (h < ha[i]) && (v < va[i]);
      fs  = (h == 0) && (v == 0);
      ls  = (h == 0);
      return {hs, vs, von, fs, ls, 12'(h), 12'(v)};
   endfunction

   task automatic step(input logic t, input logic r);
      logic [28:0] e;
      pix_tick = t;
      rst_n = r;
      for (int i = 0; i < 3; i++) begin
         if (!r) begin
            mh[i] = 0;
            mv[i] = 0;
            mo[i] = {~pol[i], ~pol[i], 3'b000, 24'd0};
         end else if (t) begin
            mo[i] = dec(i, mh[i], mv[i]);
            if (mh[i] == ha[i] + hf[i] + hw[i] + hb[i] - 1) begin
               mh[i] = 0;
               mv[i] = (mv[i] == va[i] + vf[i] + vw[i] + vb[i] - 1) ? 0 : mv[i] + 1;
            end else begin
               mh[i] = mh[i] + 1;
            end
         end
         q.push_back(mo[i]);
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         e = q.pop_front();
         vectors++;
         assert (obs[i] === e) else begin
            miscompares++;
            $error("FAIL sb_inst%0d observed=%h expected=%h", i, obs[i], e);
         end
      end
   endtask

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   int n_von, n_hs, n_fs, n_vs, n_vsp, n_ls;
   bit found;

   initial begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      chk("reset_col", col_d, 0);
      chk("reset_hsync", hs_d, 1);
      chk("reset_hsync_pol1", hs_p, 0);

      n_von = 0; n_hs = 0; n_fs = 0; n_vs = 0; n_vsp = 0;
      for (int i = 0; i < 800; i++) begin
         step(1'b1, 1'b1);
         if (i == 0) begin
            chk("first_col", col_d, 0);
            chk("first_frame_start", fs_d, 1);
            chk("first_video_on", von_d, 1);
         end
         if (i == 1) begin
            chk("second_col", col_d, 1);
            chk("second_frame_start", fs_d, 0);
         end
         if (i == 656) chk("hsync_first_low_col", hs_d, 0);
         if (i == 752) chk("hsync_after_high_col", hs_d, 1);
         n_von += int'(von_d);
         n_hs  += int'(hs_d == 1'b0);
         n_fs  += int'(fs_s);
         n_vs  += int'(vs_s == 1'b0);
         n_vsp += int'(vs_p);
      end
      chk("line_video_on_ticks", n_von, 640);
      chk("line_hsync_low_ticks", n_hs, 96);
      chk("small_frame_starts", n_fs, 5);
      chk("small_vsync_low_ticks", n_vs, 128);
      chk("small_vsync_high_pol1", n_vsp, 128);
      step(1'b1, 1'b1);
      chk("wrap_col", col_d, 0);
      chk("wrap_row", row_d, 1);
      chk("wrap_line_start", ls_d, 1);

      step(1'b1, 1'b0);
      n_ls = 0;
      for (int i = 0; i < 160; i++) begin
         step(i % 4 == 0, 1'b1);
         n_ls += int'(ls_s);
      end
      chk("paced_line_start_clocks", n_ls, 12);

      step(1'b1, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         step(1'b1, 1'b1);
         found = (col_s == 12'd11) && (row_s == 12'd9);
      end
      chk("reach_mid_sync", int'(found), 1);
      chk("mid_hsync_active", hs_s, 0);
      chk("mid_vsync_active", vs_s, 0);
      step(1'b1, 1'b0);
      chk("rst_hsync_inactive", hs_s, 1);
      chk("rst_vsync_inactive", vs_s, 1);
      chk("rst_hsync_inactive_pol1", hs_p, 0);
      step(1'b1, 1'b1);
      chk("restart_frame_start", fs_s, 1);
      chk("restart_col", col_s, 0);
      chk("restart_row", row_s, 0);
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
